clock_button_conditioner: RTL and testbench

Front-end conditioning stage for the clock core: takes five raw, bouncy push-button levels and produces the single-cycle command pulses the clock core consumes (`mode_btn`, `add_hour`, `add_minute`, `set_timer_btn`, `set_alarm_btn`). Each channel is synchronised, debounced and edge-detected. The two adjust channels also auto-repeat while held, so a long press steps the hour or minute value repeatedly. Outputs connect directly to the same-named inputs of the clock core.

---
 rtl/clock_pkg.sv | 7 +
 rtl/button_channel.sv | 65 ++++++
 rtl/clock_button_conditioner.sv | 39 +++
 tb/tb_clock_button_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared defaults and repeat-FSM state type for the clock front end.
package clock_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int REPEAT_DELAY_DEF = 16;
  localparam int REPEAT_PERIOD_DEF = 4;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;
endpackage

// File: rtl/button_channel.sv
// button_channel: synchronise, debounce and edge-detect one button, with optional auto-repeat.
module button_channel
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [1:0] sync;
  logic [DW-1:0] dcnt;
  logic lvl, lvl_q, rise, fire;
  rpt_state_t state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      dcnt <= '0;
      lvl <= 1'b0;
      lvl_q <= 1'b0;
      state <= IDLE;
      rcnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == lvl) dcnt <= '0;
      else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        dcnt <= '0;
        lvl <= ~lvl;
      end else dcnt <= dcnt + 1'b1;
      lvl_q <= lvl;
      state <= state_n;
      rcnt <= rcnt_n;
      pulse <= rise | fire;
    end
  // A low accepted level always wins, so a repeat due in the release cycle is dropped.
  always_comb begin
    rise = lvl & ~lvl_q;
    state_n = state;
    rcnt_n = rcnt + 1'b1;
    fire = 1'b0;
    if (!lvl) begin
      state_n = IDLE;
      rcnt_n = '0;
    end else if (rise) begin
      state_n = REPEAT_EN ? HOLD : IDLE;
      rcnt_n = '0;
    end else if (state == HOLD && rcnt == RW'(REPEAT_DELAY - 1)) begin
      fire = 1'b1;
      state_n = REPEAT;
      rcnt_n = '0;
    end else if (state == REPEAT && rcnt == RW'(REPEAT_PERIOD - 1)) begin
      fire = 1'b1;
      rcnt_n = '0;
    end else if (state == IDLE) rcnt_n = '0;
  end
endmodule

// File: rtl/clock_button_conditioner.sv
// clock_button_conditioner: five conditioned button channels feeding the clock core;
// only the hour and minute adjust channels auto-repeat.
module clock_button_conditioner
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode_raw,
  input  logic btn_hour_raw,
  input  logic btn_minute_raw,
  input  logic btn_timer_raw,
  input  logic btn_alarm_raw,
  output logic mode_btn,
  output logic add_hour,
  output logic add_minute,
  output logic set_timer_btn,
  output logic set_alarm_btn
);
  logic [4:0] raw, pulse;
  assign raw = {btn_alarm_raw, btn_timer_raw, btn_minute_raw, btn_hour_raw, btn_mode_raw};
  assign {set_alarm_btn, set_timer_btn, add_minute, add_hour, mode_btn} = pulse;
  for (genvar i = 0; i < 5; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN(i == 1 || i == 2)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(raw[i]),
      .pulse(pulse[i])
    );
  end
endmodule

// File: tb/tb_clock_button_conditioner.sv
// tb_clock_button_conditioner: directed scenarios plus random button activity, checked
// every cycle against a window-based behavioural model of the five channels.
module tb_clock_button_conditioner;
  localparam int D = 4;
  localparam int DLY = 16;
  localparam int PER = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] raw = '0;
  logic [4:0] outs;
  logic mode_btn, add_hour, add_minute, set_timer_btn, set_alarm_btn;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  clock_button_conditioner dut (
    .clk(clk),
    .reset(reset),
    .btn_mode_raw(raw[0]),
    .btn_hour_raw(raw[1]),
    .btn_minute_raw(raw[2]),
    .btn_timer_raw(raw[3]),
    .btn_alarm_raw(raw[4]),
    .mode_btn(mode_btn),
    .add_hour(add_hour),
    .add_minute(add_minute),
    .set_timer_btn(set_timer_btn),
    .set_alarm_btn(set_alarm_btn)
  );
  assign outs = {set_alarm_btn, set_timer_btn, add_minute, add_hour, mode_btn};
  // Model: the level is accepted once the last D synchronised samples all disagree with it;
  // pulses follow the accepted rise by one edge, repeats on a fixed schedule while held.
  int t;
  logic [1:0] rh [5];
  logic [31:0] win [5];
  logic lvl [5];
  int p [5];
  logic [4:0] exp_o;
  always @(posedge clk or negedge reset) begin : model
    logic s, old;
    logic [31:0] m;
    m = (32'd1 << D) - 1;
    if (!reset) begin
      t = 0;
      exp_o = '0;
      for (int c = 0; c < 5; c++) begin
        rh[c] = '0;
        win[c] = '0;
        lvl[c] = 1'b0;
        p[c] = -1;
      end
    end else begin
      for (int c = 0; c < 5; c++) begin
        s = rh[c][1];
        old = lvl[c];
        rh[c] = {rh[c][0], raw[c]};
        win[c] = {win[c][30:0], s};
        if (old ? ((win[c] & m) == 0) : ((win[c] & m) == m)) lvl[c] = ~old;
        exp_o[c] = old && p[c] >= 0 && (t == p[c] ||
                   ((c == 1 || c == 2) && t - p[c] >= DLY && (t - p[c] - DLY) % PER == 0));
        if (!old && lvl[c]) p[c] = t + 1;
      end
      t++;
    end
  end
  always @(negedge clk)
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (outs[c] !== exp_o[c]) begin
        fails++;
        $display("FAIL cmp ch%0d t=%0d: dut=%b model=%b", c, t, outs[c], exp_o[c]);
      end
    end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask
  task automatic watch(input int c, input int n, output int dc, output int df, output int mc);
    dc = 0;
    df = -1;
    mc = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (outs[c] === 1'b1) begin
        dc++;
        if (df < 0) df = i;
      end
      if (exp_o[c]) mc++;
    end
  endtask
  int prs [3] = '{2, 6, 40};
  initial begin
    int dc, df, mc, pr;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    #2 reset = 1'b1;
    raw[0] = 1'b1;
    watch(0, 30, dc, df, mc);
    chk("clean_count", dc, 1);
    chk("clean_latency", df, 7);
    chk("clean_model", mc, 1);
    raw[0] = 1'b0;
    watch(0, 20, dc, df, mc);
    chk("clean_release", dc, 0);
    raw[4] = 1'b1;
    @(negedge clk) raw[4] = 1'b0;
    @(negedge clk) raw[4] = 1'b1;
    @(negedge clk) raw[4] = 1'b0;
    @(negedge clk) raw[4] = 1'b1;
    watch(4, 30, dc, df, mc);
    chk("bounce_count", dc, 1);
    chk("bounce_latency", df, 7);
    raw[4] = 1'b0;
    watch(4, 20, dc, df, mc);
    raw[4] = 1'b1;
    repeat (3) @(negedge clk);
    raw[4] = 1'b0;
    watch(4, 20, dc, df, mc);
    chk("glitch_count", dc, 0);
    raw[1] = 1'b1;
    watch(1, 40, dc, df, mc);
    chk("repeat_count", dc, 6);
    chk("repeat_first", df, 7);
    chk("repeat_model", mc, 6);
    raw[1] = 1'b0;
    watch(1, 20, dc, df, mc);
    chk("repeat_tail_count", dc, 1);
    chk("repeat_tail_pos", df, 3);
    raw[2] = 1'b1;
    watch(2, 15, dc, df, mc);
    chk("short_count", dc, 1);
    chk("short_latency", df, 7);
    raw[2] = 1'b0;
    watch(2, 25, dc, df, mc);
    chk("short_no_repeat", dc, 0);
    chk("short_model", mc, 0);
    raw[3] = 1'b1;
    raw[1] = 1'b1;
    repeat (7) @(negedge clk);
    chk("simul_pulses", {outs[3], outs[1]}, 2'b11);
    raw[3] = 1'b0;
    raw[1] = 1'b0;
    watch(1, 30, dc, df, mc);
    chk("simul_release", dc, 0);
    raw[1] = 1'b1;
    watch(1, 27, dc, df, mc);
    chk("pre_reset_count", dc, 3);
    chk("pre_reset_pulse", outs[1], 1);
    #2 reset = 1'b0;
    #1 chk("reset_immediate", outs, 0);
    repeat (3) @(negedge clk);
    chk("reset_held", outs, 0);
    #2 reset = 1'b1;
    watch(1, 30, dc, df, mc);
    chk("post_reset_count", dc, 3);
    chk("post_reset_latency", df, 7);
    raw[1] = 1'b0;
    watch(1, 20, dc, df, mc);
    for (int seg = 0; seg < 15; seg++) begin
      pr = prs[$urandom_range(0, 2)];
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #2 reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #2 reset = 1'b1;
      end
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        for (int c = 0; c < 5; c++)
          if ($urandom_range(0, pr - 1) == 0) raw[c] = ~raw[c];
      end
    end
    raw = '0;
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
